// File: rtl/text_scheduler.sv
// text_scheduler: frame-synchronous sequencer that drifts, blinks and gaps a set of text overlays
module text_scheduler #(
  parameter int NUM_TEXTS    = 4,
  parameter int DWELL_FRAMES = 240,
  parameter int BLINK_FRAMES = 64,
  parameter int BLINK_HALF   = 8,
  parameter int GAP_FRAMES   = 30,
  parameter int STEP_FRAMES  = 4,
  parameter int MAX_DX       = 16,
  parameter int MAX_DY       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 enable,
  input  logic                 pause,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [NUM_TEXTS-1:0] text_active_in,
  output logic [9:0]           x_shift,
  output logic [9:0]           y_shift,
  output logic [2:0]           text_sel,
  output logic                 overlay_active,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, SHOW, BLINK, GAP} state_t;
  localparam logic [8:0] SHOW_LAST  = 9'(DWELL_FRAMES - 1);
  localparam logic [8:0] BLINK_LAST = 9'(BLINK_FRAMES - 1);
  localparam logic [8:0] GAP_LAST   = 9'(GAP_FRAMES - 1);
  localparam logic [8:0] HALF       = 9'(BLINK_HALF);
  localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
  localparam logic [5:0] LIM_X      = 6'(MAX_DX);
  localparam logic [5:0] LIM_Y      = 6'(MAX_DY);
  localparam logic [2:0] SEL_LAST   = 3'(NUM_TEXTS - 1);
  state_t     state, state_d;
  logic [8:0] frame_cnt, frame_cnt_d;
  logic [7:0] step_cnt, step_cnt_d;
  logic [5:0] dx, dx_d, dy, dy_d;
  logic       dir_x, dir_x_d, dir_y, dir_y_d;
  logic [2:0] sel_d;
  logic       ev, last, gate, overlay_d;
  logic [7:0] act;
  logic [6:0] ax, ay;
  function automatic logic [6:0] step_axis(input logic [5:0] v, input logic dir, input logic [5:0] m);
    return m == 6'd0 ? {dir, v} :
           !dir && v == m ? {1'b1, v - 6'd1} :
           !dir ? {1'b0, v + 6'd1} :
           v == 6'd0 ? {1'b0, 6'd1} : {1'b1, v - 6'd1};
  endfunction
  assign ev      = frame_start & ~pause & enable;
  assign last    = frame_cnt == (state == SHOW ? SHOW_LAST : state == BLINK ? BLINK_LAST : GAP_LAST);
  assign gate    = state == SHOW || (state == BLINK && ((frame_cnt / HALF) & 9'd1) == 9'd0);
  assign act     = 8'(text_active_in);
  assign ax      = step_axis(dx, dir_x, LIM_X);
  assign ay      = step_axis(dy, dir_y, LIM_Y);
  assign x_shift = x - 10'({dx, 3'b000});
  assign y_shift = y - 10'({dy, 3'b000});
  assign busy    = state != IDLE;
  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    step_cnt_d  = step_cnt;
    dx_d        = dx;
    dy_d        = dy;
    dir_x_d     = dir_x;
    dir_y_d     = dir_y;
    sel_d       = text_sel;
    overlay_d   = gate & act[text_sel];
    if (ev && state == IDLE)
      state_d = SHOW;
    else if (ev) begin
      frame_cnt_d = last ? 9'd0 : frame_cnt + 9'd1;
      state_d     = !last ? state : state == SHOW ? BLINK : state == BLINK ? GAP : SHOW;
      sel_d       = !(last && state == GAP) ? text_sel : text_sel == SEL_LAST ? 3'd0 : text_sel + 3'd1;
      if (state == SHOW) begin
        step_cnt_d = step_cnt == STEP_LAST ? 8'd0 : step_cnt + 8'd1;
        {dir_x_d, dx_d} = step_cnt == STEP_LAST ? ax : {dir_x, dx};
        {dir_y_d, dy_d} = step_cnt == STEP_LAST ? ay : {dir_y, dy};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state          <= IDLE;
      frame_cnt      <= 9'd0;
      step_cnt       <= 8'd0;
      dx             <= 6'd0;
      dy             <= 6'd0;
      dir_x          <= 1'b0;
      dir_y          <= 1'b0;
      text_sel       <= 3'd0;
      overlay_active <= 1'b0;
    end else begin
      state          <= state_d;
      frame_cnt      <= frame_cnt_d;
      step_cnt       <= step_cnt_d;
      dx             <= dx_d;
      dy             <= dy_d;
      dir_x          <= dir_x_d;
      dir_y          <= dir_y_d;
      text_sel       <= sel_d;
      overlay_active <= overlay_d;
    end
  end
endmodule

// File: doc/text_scheduler.md
# text_scheduler

Frame-synchronous controller that sequences up to eight fixed-position text overlay generators on the VGA path. It picks which text is shown, moves it around the screen by feeding shifted pixel coordinates to the text generators (a bouncing drift in 8-pixel cells), blinks it out, and leaves a blank gap before moving to the next text. It sits between the VGA timing generator and the text bitmap modules, and its registered `overlay_active` feeds the colour mux.

## Interface
- `NUM_TEXTS`, 4: number of text generators, 2..8.
- `DWELL_FRAMES`, 240: frames spent in SHOW, 1..511.
- `BLINK_FRAMES`, 64: frames spent in BLINK, 1..511.
- `BLINK_HALF`, 8: frames per on/off half-period in BLINK, 1..255.
- `GAP_FRAMES`, 30: frames spent in GAP, 1..511.
- `STEP_FRAMES`, 4: frames between drift steps, 1..255.
- `MAX_DX`, 16 / `MAX_DY`, 8: drift limits in cells, 0..63.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse per frame from VGA timing.
- `enable` in 1: run the sequence.
- `pause` in 1: ignore `frame_start` while high.
- `x`, `y` in 10 each: current pixel coordinates.
- `text_active_in` in NUM_TEXTS: `overlay_active` from each text generator, driven by `x_shift`/`y_shift`.
- `x_shift`, `y_shift` out 10 each: combinational. `x_shift` = x − {dx,3'b000} and `y_shift` = y − {dy,3'b000}, both mod 2^10.
- `text_sel` out 3: index of the current text.
- `overlay_active` out 1: registered, gated pixel-on.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Registers:
  - `state` ∈ {IDLE, SHOW, BLINK, GAP}.
  - `frame_cnt` (9 bits) and `step_cnt` (8 bits).
  - `dx`, `dy` (6 bits each) and direction bits `dir_x`, `dir_y` (0 = increasing).
  - `text_sel`.
- Reset, or `enable` low in any cycle: next cycle the block is in IDLE with every register 0, `overlay_active` = 0 and `busy` = 0. This also applies mid-sequence, and `enable` low takes priority over `frame_start`.
- A frame event is `frame_start & ~pause & enable`. All state, counter and drift updates happen only on frame events.
- IDLE → SHOW on the first frame event. `frame_cnt` = 0.
- In SHOW, BLINK and GAP, with LEN = DWELL_FRAMES, BLINK_FRAMES or GAP_FRAMES:
  - On a frame event with `frame_cnt` = LEN−1, clear `frame_cnt` and go to the next state.
  - Otherwise increment `frame_cnt`.
- State order: SHOW → BLINK → GAP → SHOW. On GAP → SHOW, `text_sel` increments, wrapping from NUM_TEXTS−1 to 0.
- Drift runs in SHOW only:
  - On each frame event, if `step_cnt` = STEP_FRAMES−1, clear it and step both axes; else increment it.
  - Axis step, with limit M: if increasing and the value = M, set `dir`=1 and value−1; if increasing, value+1; if decreasing and the value = 0, set `dir`=0 and value+1; otherwise value−1.
  - M = 0: the value stays 0.
  - `dx`/`dy`/`dir`/`step_cnt` hold through BLINK and GAP and carry over to the next text.
- Gate:
  - SHOW: 1.
  - BLINK: 1 when (`frame_cnt` / BLINK_HALF) is even, else 0.
  - IDLE and GAP: 0.
- `overlay_active` <= gate & `text_active_in[text_sel]`.

## Timing
- State and counter updates take effect on the clock edge that samples the frame event. New values are visible from the cycle after `frame_start`, i.e. within vblank, so there is no mid-frame tearing.
- `x_shift`/`y_shift` have 0-cycle latency.
- `overlay_active` has 1-cycle latency from `x`/`y`/`text_active_in`. The VGA path must delay sync and blank by one cycle to match.
- SHOW lasts exactly DWELL_FRAMES frame events, BLINK exactly BLINK_FRAMES, and GAP exactly GAP_FRAMES.
- `pause` stretches every phase by the number of suppressed pulses. `pause` has no effect on the output gating.
- `frame_start` held high for several cycles counts as one event per high cycle. This is a caller error and is not filtered.

## Test plan
Bench parameters: NUM_TEXTS=3, DWELL=6, BLINK=4, BLINK_HALF=2, GAP=2, STEP=1, MAX_DX=3, MAX_DY=1.

1. Reset and enable:
   - Stimulus: hold `rst_n`=0 for 3 cycles, then set `enable`=1 with no frame event.
   - Required: `busy`=0, `text_sel`=0, `x_shift`=x, `overlay_active`=0.
   - Then one frame event: `busy`=1 and `overlay_active` follows `text_active_in[0]` one cycle late.
2. Drift:
   - Stimulus: a run of frame events in SHOW.
   - Required: `dx` reads 0 after entering SHOW, then 1, 2, 3, 2, 1, 0 across the next frames.
   - Required: `dy` reads 0, 1, 0, 1, …
   - Required: with x=200 and `dx`=2, `x_shift`=184. With y=5 and `dy`=1, `y_shift`=1021.
3. Full cycle:
   - Required: SHOW spans 6 events, BLINK 4, GAP 2, after which `text_sel`=1. After three cycles `text_sel` wraps to 0.
   - Required: BLINK gate pattern is 1,1,0,0. GAP holds `overlay_active`=0 even with `text_active_in` all ones.
4. Pause:
   - Stimulus: assert `pause` over 3 `frame_start` pulses during SHOW.
   - Required: `frame_cnt`, `dx` and `dy` are unchanged, and SHOW ends 3 pulses later than without the pause.
5. Abort:
   - Stimulus: drop `enable` in the same cycle as `frame_start`, mid-BLINK.
   - Required: next cycle the block is in IDLE with `dx`=`dy`=0, `text_sel`=0 and `overlay_active`=0.
   - Required: re-enabling restarts at SHOW with text 0 on the next frame event.
6. Selection:
   - Stimulus: drive `text_active_in`=3'b010.
   - Required: `overlay_active`=1 only while `text_sel`=1 and the gate is 1.
